palette_cycler: RTL and testbench
=================================

// Module: palette_cycler
// PURPOSE
//  Parametrised, writable colour palette with hardware colour cycling for animated tiles
//  (water ripple, waterfalls, flashing lights). Sits between the tile/sprite pixel fetch and
//  the VGA colour mux. Maps an IDX_W-bit colour index to 4:4:4 RGB with a fixed 2-cycle latency.
//  Entries CYC_LO..CYC_HI rotate by one slot every FRAMES_PER_STEP frames while cycling is enabled.
// PARAMETERS
//  IDX_W           3      index width; palette holds N = 2**IDX_W entries
//  COLOR_W         4      bits per colour channel
//  CYC_LO          1      first entry of the rotating band (0 <= CYC_LO <= CYC_HI < N)
//  CYC_HI          5      last entry of the rotating band
//  FRAMES_PER_STEP 8      frame_tick pulses per rotation step (>= 1)
//  DEFAULT_PAL     {07D,420,9CE,000,860,3AF,EFE,554}  reset contents, entry 0 first, N*3*COLOR_W bits
// PORTS
//  Clk        in   1             system clock; all state changes on its rising edge
//  Reset      in   1             synchronous reset, active-high
//  frame_tick in   1             one-cycle pulse per frame (start of vblank)
//  cycle_en   in   1             1 = rotation advances on frame steps; 0 = phase frozen
//  pix_valid  in   1             index is a valid pixel request this cycle
//  pix_index  in   IDX_W         colour index to look up
//  wr_en      in   1             palette write strobe
//  wr_addr    in   IDX_W         physical entry to write (no rotation applied)
//  wr_data    in   3*COLOR_W     {R,G,B} to write
//  red        out  COLOR_W       looked-up red; 0 when rgb_valid = 0
//  green      out  COLOR_W       looked-up green; 0 when rgb_valid = 0
//  blue       out  COLOR_W       looked-up blue; 0 when rgb_valid = 0
//  rgb_valid  out  1             pix_valid delayed by 2 cycles
//  phase      out  clog2(BAND)   current rotation offset, BAND = CYC_HI-CYC_LO+1 (width min 1)
// BEHAVIOUR
//  Clock/reset: single clock Clk; Reset is synchronous, active-high.
//  Reset:
//   - Palette is reloaded from DEFAULT_PAL.
//   - phase = 0, frame counter = 0, both pipeline valids = 0.
//   - red/green/blue = 0, rgb_valid = 0.
//   - Reset mid-lookup discards in-flight pixels; no output is produced for them.
//  Frame counter fcnt (0..FRAMES_PER_STEP-1):
//   - Advances on frame_tick only while cycle_en = 1; holds when cycle_en = 0.
//   - On frame_tick with fcnt = FRAMES_PER_STEP-1: fcnt -> 0 and phase -> (phase+1) mod BAND.
//   - Phase wraps BAND-1 -> 0.
//   - If BAND = 1, phase stays 0.
//  Address remap (stage 1, registered):
//   - If CYC_LO <= pix_index <= CYC_HI: phys = CYC_LO + ((pix_index-CYC_LO+phase) mod BAND).
//   - Otherwise phys = pix_index.
//   - Uses the phase value before any update in the same cycle.
//   - Mod is computed as a compare-and-subtract; no divider.
//  Read (stage 2, registered):
//   - {red,green,blue} <= pal[phys] and rgb_valid <= stage-1 valid.
//   - Invalid slots drive 0 on all colour outputs.
//  Latency: exactly 2 cycles from pix_valid/pix_index to rgb_valid/RGB. Throughput 1 pixel/cycle, no stalls.
//  Writes:
//   - pal[wr_addr] <= wr_data on wr_en, same edge.
//   - A stage-2 read of the same entry on that edge returns the OLD value (read-before-write).
//   - Writes and rotation are independent: rotation changes only the index-to-entry mapping.
//     Stored data never moves.
//  Simultaneous events: write, frame step and lookups in one cycle all take effect. Each lookup
//   uses the pre-edge phase and pre-edge palette contents.
// TESTING
//  1 Reset, cycle_en=0, indices 0..7 back-to-back -> 2 cycles later RGB = 07D,420,9CE,000,860,3AF,EFE,554; rgb_valid high 8 cycles.
//  2 cycle_en=1, 8 frame_ticks -> phase=1; index 1 returns 9CE, index 5 returns 420, index 0/6/7 unchanged.
//  3 40 frame_ticks with cycle_en=1 -> phase wraps 4 -> 0 at tick 40; cycle_en=0 for 8 further ticks -> phase unchanged.
//  4 wr_en addr 3 data F00 in the same cycle a stage-2 read of entry 3 -> old 000 output; next read of 3 -> F00.
//  5 Reset asserted while 2 pixels in flight, with phase=3 -> next cycle rgb_valid=0, RGB=0, phase=0, palette=DEFAULT_PAL.
//  6 pix_valid=0 gaps between lookups -> rgb_valid mirrors the input gaps with 2-cycle delay; RGB=0 in the gap cycles.

Source files
------------

// File: rtl/palette_cycler.sv
// palette_cycler: writable colour palette with a rotating band of entries.
// A colour index is remapped through the current rotation phase (stage 1),
// then looked up in the palette (stage 2), so RGB appears exactly two cycles
// after the request. The rotation phase advances one slot every
// FRAMES_PER_STEP frame ticks while cycling is enabled. Stored colours never
// move; only the index-to-entry mapping inside the band changes.
//
// Handshake: pix_valid qualifies pix_index in the same cycle. There is no
// ready; the pipeline accepts one pixel per cycle and never stalls.
// rgb_valid is pix_valid delayed by two cycles. The colour outputs are
// forced to zero in every cycle where rgb_valid is low.
module palette_cycler #(
    parameter int IDX_W           = 3,
    parameter int COLOR_W         = 4,
    parameter int CYC_LO          = 1,
    parameter int CYC_HI          = 5,
    parameter int FRAMES_PER_STEP = 8,
    parameter logic [(2**IDX_W)*3*COLOR_W-1:0] DEFAULT_PAL =
        96'h07D_420_9CE_000_860_3AF_EFE_554
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 cycle_en,
    input  logic                 pix_valid,
    input  logic [IDX_W-1:0]     pix_index,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0] wr_data,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 rgb_valid,
    output logic [(((CYC_HI-CYC_LO+1) > 1) ? $clog2(CYC_HI-CYC_LO+1) : 1)-1:0] phase
);

    localparam int N     = 2**IDX_W;
    localparam int RGB_W = 3*COLOR_W;
    localparam int BAND  = CYC_HI - CYC_LO + 1;
    localparam int PH_W  = (BAND > 1) ? $clog2(BAND) : 1;
    localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BAND - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

    // Remap arithmetic runs one bit wider than the index so that
    // offset + phase (always < 2*BAND <= 2*N) cannot overflow.
    localparam logic [IDX_W:0] LO_X   = (IDX_W+1)'(CYC_LO);
    localparam logic [IDX_W:0] HI_X   = (IDX_W+1)'(CYC_HI);
    localparam logic [IDX_W:0] BAND_X = (IDX_W+1)'(BAND);

    logic [RGB_W-1:0] pal [N];
    logic [FC_W-1:0]  fcnt;

    logic             s1_valid;
    logic [IDX_W-1:0] s1_phys;
    logic [RGB_W-1:0] rgb_q;

    logic [IDX_W:0]   idx_x;
    logic [IDX_W:0]   ph_x;
    logic [IDX_W:0]   off_x;
    logic [IDX_W:0]   sum_x;
    logic [IDX_W:0]   mod_x;
    logic [IDX_W:0]   phys_x;
    logic             in_band;
    logic [IDX_W-1:0] phys;

    // Frame counter and rotation phase; both freeze while cycle_en is low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fcnt  <= '0;
            phase <= '0;
        end else if (frame_tick && cycle_en) begin
            if (fcnt == FC_LAST) begin
                fcnt  <= '0;
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Index remap: rotate inside the band using compare-and-subtract as the mod.
    always_comb begin
        idx_x   = {1'b0, pix_index};
        ph_x    = (IDX_W+1)'(phase);
        in_band = (idx_x >= LO_X) && (idx_x <= HI_X);
        off_x   = idx_x - LO_X;
        sum_x   = off_x + ph_x;
        mod_x   = (sum_x >= BAND_X) ? (sum_x - BAND_X) : sum_x;
        phys_x  = mod_x + LO_X;
        phys    = in_band ? phys_x[IDX_W-1:0] : pix_index;
    end

    // Stage 1: register the physical entry address and its valid bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_phys  <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_phys  <= phys;
        end
    end

    // Palette storage: reset reloads the defaults (entry 0 in the top bits);
    // a write lands on the same edge as any read, which still sees the old value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                pal[i] <= DEFAULT_PAL[(N-1-i)*RGB_W +: RGB_W];
            end
        end else if (wr_en) begin
            pal[wr_addr] <= wr_data;
        end
    end

    // Stage 2: palette read, colour forced to zero for empty slots.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_valid <= 1'b0;
            rgb_q     <= '0;
        end else begin
            rgb_valid <= s1_valid;
            rgb_q     <= s1_valid ? pal[s1_phys] : '0;
        end
    end

    assign red   = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_q[COLOR_W-1   -: COLOR_W];

endmodule

// File: tb/tb_palette_cycler.sv
// Bench for palette_cycler: directed scenarios followed by random traffic.
// A reference model predicts every output; a monitor compares each cycle.
module tb_palette_cycler;

    localparam int IDX_W = 3;
    localparam int COLOR_W = 4;
    localparam int LO = 1;
    localparam int HI = 5;
    localparam int BAND = HI - LO + 1;
    localparam int FPS = 8;
    localparam int N = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        cycle_en;
    logic        pix_valid;
    logic [2:0]  pix_index;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        rgb_valid;
    logic [2:0]  phase;

    logic [11:0] default_colors [N] = '{12'h07D, 12'h420, 12'h9CE, 12'h000,
                                        12'h860, 12'h3AF, 12'hEFE, 12'h554};

    int n_cmp = 0;
    int n_fail = 0;

    logic [11:0] exp_q[$];
    logic [11:0] out_log[$];

    // Reference model state
    logic [11:0] mdl_pal [N];
    int          ticks = 0;
    logic        pend_v = 1'b0;
    int          pend_phys = 0;

    palette_cycler #(
        .IDX_W(IDX_W), .COLOR_W(COLOR_W), .CYC_LO(LO), .CYC_HI(HI),
        .FRAMES_PER_STEP(FPS)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .cycle_en(cycle_en),
        .pix_valid(pix_valid), .pix_index(pix_index), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .red(red), .green(green),
        .blue(blue), .rgb_valid(rgb_valid), .phase(phase)
    );

    // Clock
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int model_phase();
        return (ticks / FPS) % BAND;
    endfunction

    function automatic int remap(input int idx, input int ph);
        if (idx >= LO && idx <= HI) return LO + ((idx - LO + ph) % BAND);
        return idx;
    endfunction

    // Reference model: evaluated at each rising edge on the pre-edge inputs.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) mdl_pal[i] = default_colors[i];
            ticks = 0;
            pend_v = 1'b0;
        end else begin
            if (pend_v) exp_q.push_back(mdl_pal[pend_phys]);
            pend_v = pix_valid;
            pend_phys = remap(int'(pix_index), model_phase());
            if (wr_en) mdl_pal[wr_addr] = wr_data;
            if (frame_tick && cycle_en) ticks++;
        end
    end

    // Monitor: compares outputs against the expected queue on the falling edge.
    always @(negedge Clk) begin
        logic [11:0] e;
        check("rgb_valid", {31'b0, rgb_valid}, {31'b0, exp_q.size() != 0});
        if (rgb_valid) begin
            out_log.push_back({red, green, blue});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rgb_data", {red, green, blue}, e);
            end
        end else begin
            check("rgb_zero", {red, green, blue}, 0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        check("phase", phase, model_phase());
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic lookup(input int idx);
        pix_valid = 1'b1;
        pix_index = 3'(idx);
        step();
        pix_valid = 1'b0;
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    initial begin
        logic [9:0] gap_pat;
        int ones;
        Reset = 1'b1; frame_tick = 1'b0; cycle_en = 1'b0; pix_valid = 1'b0;
        pix_index = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        check("reset_rgb_valid", {31'b0, rgb_valid}, 0);
        check("reset_rgb", {red, green, blue}, 0);
        check("reset_phase", phase, 0);
        Reset = 1'b0;
        step();

        // Default palette, no rotation, back-to-back lookups
        out_log.delete();
        for (int i = 0; i < N; i++) begin
            pix_valid = 1'b1; pix_index = 3'(i); step();
        end
        pix_valid = 1'b0;
        drain();
        check("t1_count", out_log.size(), 8);
        for (int i = 0; i < N && i < out_log.size(); i++)
            check("t1_default", out_log[i], default_colors[i]);

        // One rotation step
        cycle_en = 1'b1;
        frame_ticks(8);
        check("t2_phase", phase, 1);
        out_log.delete();
        lookup(1); lookup(5); lookup(0); lookup(6); lookup(7);
        drain();
        check("t2_count", out_log.size(), 5);
        if (out_log.size() == 5) begin
            check("t2_idx1", out_log[0], 12'h9CE);
            check("t2_idx5", out_log[1], 12'h420);
            check("t2_idx0", out_log[2], 12'h07D);
            check("t2_idx6", out_log[3], 12'hEFE);
            check("t2_idx7", out_log[4], 12'h554);
        end

        // Phase wrap at tick 40, then frozen
        frame_ticks(31);
        check("t3_phase39", phase, 4);
        frame_ticks(1);
        check("t3_phase40", phase, 0);
        cycle_en = 1'b0;
        frame_ticks(8);
        check("t3_frozen", phase, 0);

        // Write colliding with a stage-2 read of the same entry
        out_log.delete();
        pix_valid = 1'b1; pix_index = 3'd3; step();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 12'hF00; step();
        wr_en = 1'b0; pix_valid = 1'b0;
        drain();
        check("t4_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t4_old", out_log[0], 12'h000);
            check("t4_new", out_log[1], 12'hF00);
        end

        // Reset with pixels in flight at phase 3
        cycle_en = 1'b1;
        frame_ticks(24);
        check("t5_phase3", phase, 3);
        pix_valid = 1'b1; pix_index = 3'd2; step();
        Reset = 1'b1; pix_index = 3'd4; step();
        check("t5_rgb_valid", {31'b0, rgb_valid}, 0);
        check("t5_rgb", {red, green, blue}, 0);
        check("t5_phase", phase, 0);
        Reset = 1'b0; pix_valid = 1'b0; cycle_en = 1'b0;
        step();
        out_log.delete();
        for (int i = 0; i < N; i++) begin
            pix_valid = 1'b1; pix_index = 3'(i); step();
        end
        pix_valid = 1'b0;
        drain();
        check("t5_count", out_log.size(), 8);
        for (int i = 0; i < N && i < out_log.size(); i++)
            check("t5_default", out_log[i], default_colors[i]);

        // Gaps between lookups
        gap_pat = 10'b1011001101;
        ones = 0;
        out_log.delete();
        for (int i = 0; i < 10; i++) begin
            pix_valid = gap_pat[i];
            pix_index = 3'($urandom_range(0, 7));
            if (gap_pat[i]) ones++;
            step();
        end
        pix_valid = 1'b0;
        drain();
        check("t6_count", out_log.size(), ones);

        // Random traffic: lookups, writes, frame ticks, occasional reset
        for (int i = 0; i < 1500; i++) begin
            Reset      = ($urandom_range(0, 127) == 0);
            cycle_en   = ($urandom_range(0, 7) != 0);
            frame_tick = ($urandom_range(0, 1) == 0);
            pix_valid  = ($urandom_range(0, 3) != 0);
            pix_index  = 3'($urandom_range(0, 7));
            wr_en      = ($urandom_range(0, 5) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 12'($urandom_range(0, 4095));
            step();
        end
        Reset = 1'b0; frame_tick = 1'b0; pix_valid = 1'b0; wr_en = 1'b0;
        drain();
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
